// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// loads the IF/ID pipeline register, with stall, redirect/squash and end-of-program halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'd404
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] COUNT_MAX = '1;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] count_q, count_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            target_bad;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] count_inc;

  // Redirect target: taken branch has priority over jump; low bits always forced to zero.
  always_comb begin
    redirect   = branch_taken | jump;
    target     = branch_taken ? {branch_target[31:2], 2'b00}
                              : {pc4_q[31:28], jump_index, 2'b00};
    target_bad = branch_taken & (branch_target[1:0] != 2'b00);
    pc_inc     = pc_q + XLEN'(4);
    count_inc  = (count_q == COUNT_MAX) ? count_q : count_q + XLEN'(1);
  end

  // Next-state and next-register logic; redirect beats halt check, which beats stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    mis_d    = mis_q;
    count_d  = count_q;

    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (target_bad) mis_d = 1'b1;
        end else if (pc_q >= PC_LIMIT) begin
          instr_d  = '0;
          pc4_d    = '0;
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (!stall) begin
          pc_d    = pc_inc;
          instr_d = im_instr;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          count_d = count_inc;
        end
      end
      HALT: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (redirect) begin
          pc_d     = target;
          halted_d = 1'b0;
          state_d  = RUN;
          if (target_bad) mis_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
      count_q  <= count_d;
    end
  end

  assign im_pc        = pc_q;
  assign ifid_instr   = instr_q;
  assign ifid_pc4     = pc4_q;
  assign ifid_valid   = valid_q;
  assign halted       = halted_q;
  assign misalign_err = mis_q;
  assign fetch_count  = count_q;

endmodule
